// File: rtl/lsu_master.sv
// lsu_master: memory-stage load/store initiator.
// Checks alignment of a decoded load/store and issues a word-addressed memory
// request with byte enables and a req/ack handshake. It formats the returned
// load data and holds the pipeline until the access completes or times out.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   op_valid/op_write     M-stage load/store request, 1 = store
//   op_size/op_unsigned   00 word, 01 half, 11 byte, 10 reserved; zero-extend
//   op_addr/op_wdata      byte address, right-aligned store data
//   stall                 combinational pipeline freeze (M and earlier)
//   rdata/rdata_valid     formatted load data, one-cycle valid pulse
//   addr_err/timeout_err  one-cycle error pulses
//   mem_*                 memory request port (req/we/addr/be/wdata, ack/rdata)
module lsu_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_write,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic        timeout_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               misaligned;
  logic               expired;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c;
  logic [31:0]        load_fmt_c;

  // Access attributes captured at request time for load formatting
  logic [1:0]         size_q, size_nxt;
  logic               uns_q, uns_nxt;
  logic [1:0]         lane_q, lane_nxt;

  logic               mem_req_nxt, mem_we_nxt;
  logic [31:0]        mem_addr_nxt, mem_wdata_nxt, rdata_nxt;
  logic [3:0]         mem_be_nxt;
  logic               rdata_valid_nxt, addr_err_nxt, timeout_err_nxt;

  // Alignment check; the reserved size is treated as misaligned
  always_comb begin
    misaligned = 1'b0;
    case (op_size)
      SZ_WORD: misaligned = (op_addr[1:0] != 2'b00);
      SZ_HALF: misaligned = op_addr[0];
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  end

  assign stall   = op_valid & ~misaligned & (state != DONE);
  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

  // Byte enables and lane-replicated store data
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = op_wdata;
    case (op_size)
      SZ_HALF: begin
        be_c    = op_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{op_wdata[15:0]}};
      end
      SZ_BYTE: begin
        be_c    = 4'b0001 << op_addr[1:0];
        wdata_c = {4{op_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Lane extract and sign/zero extension of the returned word
  always_comb begin
    logic [15:0] half_lane;
    logic [7:0]  byte_lane;
    half_lane  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lane_q)
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    case (size_q)
      SZ_HALF: load_fmt_c = {{16{~uns_q & half_lane[15]}}, half_lane};
      SZ_BYTE: load_fmt_c = {{24{~uns_q & byte_lane[7]}}, byte_lane};
      default: load_fmt_c = mem_rdata;
    endcase
  end

  // State register and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; ack takes priority over expiry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (op_valid && !misaligned) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
        end
      end
      REQ: begin
        if (mem_ack || expired) state_nxt = DONE;
        else                    cnt_nxt   = cnt + CNT_W'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    mem_req_nxt     = mem_req;
    mem_we_nxt      = mem_we;
    mem_addr_nxt    = mem_addr;
    mem_be_nxt      = mem_be;
    mem_wdata_nxt   = mem_wdata;
    rdata_nxt       = rdata;
    size_nxt        = size_q;
    uns_nxt         = uns_q;
    lane_nxt        = lane_q;
    rdata_valid_nxt = 1'b0;
    addr_err_nxt    = 1'b0;
    timeout_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid) begin
          if (misaligned) begin
            addr_err_nxt = 1'b1;
          end else begin
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = op_write;
            mem_addr_nxt  = {op_addr[31:2], 2'b00};
            mem_be_nxt    = be_c;
            mem_wdata_nxt = wdata_c;
            size_nxt      = op_size;
            uns_nxt       = op_unsigned;
            lane_nxt      = op_addr[1:0];
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          if (!mem_we) begin
            rdata_nxt       = load_fmt_c;
            rdata_valid_nxt = 1'b1;
          end
        end else if (expired) begin
          mem_req_nxt     = 1'b0;
          timeout_err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and access-attribute registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
      timeout_err <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      lane_q      <= '0;
    end else begin
      mem_req     <= mem_req_nxt;
      mem_we      <= mem_we_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_be      <= mem_be_nxt;
      mem_wdata   <= mem_wdata_nxt;
      rdata       <= rdata_nxt;
      rdata_valid <= rdata_valid_nxt;
      addr_err    <= addr_err_nxt;
      timeout_err <= timeout_err_nxt;
      size_q      <= size_nxt;
      uns_q       <= uns_nxt;
      lane_q      <= lane_nxt;
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// tb_lsu_master: directed bench for lsu_master with a transaction-level model
// checked every cycle, plus hand-computed literal expectations per test.
module tb_lsu_master;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_write, op_unsigned;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata;
  logic        stall, rdata_valid, addr_err, timeout_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_write(op_write), .op_size(op_size),
    .op_unsigned(op_unsigned), .op_addr(op_addr), .op_wdata(op_wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .addr_err(addr_err), .timeout_err(timeout_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (arithmetic on access size) ----------------
  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4;
      2'b01:   return 2;
      2'b11:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit bad(input logic [1:0] sz, input logic [31:0] a);
    int nb;
    nb = nbytes(sz);
    return (nb == 0) || ((a % nb) != 0);
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [31:0] a);
    int nb;
    nb = nbytes(sz);
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] wd_of(input logic [1:0] sz, input logic [31:0] wd);
    case (nbytes(sz))
      2:       return (wd & 32'h0000_FFFF) * 32'h0001_0001;
      1:       return (wd & 32'h0000_00FF) * 32'h0101_0101;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] fmt(input logic [31:0] rd, input logic [1:0] sz,
                                      input bit uns, input int off);
    int nb;
    longint v;
    nb = nbytes(sz);
    v  = longint'(rd >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    return 32'(v);
  endfunction

  bit          checking = 1'b0;
  bit          m_busy, m_ret, m_uns;
  int          m_wait, m_off;
  logic [1:0]  m_sz;
  logic        exp_req, exp_we, exp_rv, exp_ae, exp_te;
  logic [31:0] exp_addr, exp_wd, exp_rd;
  logic [3:0]  exp_be;

  always @(posedge clk) begin
    if (rst) begin
      checking <= 1'b1;
      m_busy <= 1'b0; m_ret <= 1'b0; m_wait <= 0;
      exp_req <= 1'b0; exp_we <= 1'b0; exp_addr <= '0; exp_be <= '0; exp_wd <= '0;
      exp_rd <= '0; exp_rv <= 1'b0; exp_ae <= 1'b0; exp_te <= 1'b0;
    end else begin
      exp_rv <= 1'b0; exp_ae <= 1'b0; exp_te <= 1'b0;
      if (m_ret) begin
        m_ret <= 1'b0;
      end else if (m_busy) begin
        if (mem_ack) begin
          m_busy <= 1'b0; m_ret <= 1'b1; exp_req <= 1'b0;
          if (!exp_we) begin
            exp_rd <= fmt(mem_rdata, m_sz, m_uns, m_off);
            exp_rv <= 1'b1;
          end
        end else if (m_wait + 1 == int'(TO)) begin
          m_busy <= 1'b0; m_ret <= 1'b1; exp_req <= 1'b0; exp_te <= 1'b1;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (op_valid) begin
        if (bad(op_size, op_addr)) begin
          exp_ae <= 1'b1;
        end else begin
          m_busy <= 1'b1; m_wait <= 0; exp_req <= 1'b1;
          exp_we   <= op_write;
          exp_addr <= op_addr & ~32'h3;
          exp_be   <= be_of(op_size, op_addr);
          exp_wd   <= wd_of(op_size, op_wdata);
          m_sz <= op_size; m_uns <= op_unsigned; m_off <= int'(op_addr % 4);
        end
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("stall", 32'(stall), 32'(op_valid && !bad(op_size, op_addr) && !m_ret));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("rdata_valid", 32'(rdata_valid), 32'(exp_rv));
      chk("addr_err", 32'(addr_err), 32'(exp_ae));
      chk("timeout_err", 32'(timeout_err), 32'(exp_te));
      chk("rdata", rdata, exp_rd);
      if (exp_req) begin
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", 32'(mem_be), 32'(exp_be));
        chk("mem_wdata", mem_wdata, exp_wd);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] cap_addr, cap_wd;
  logic [3:0]  cap_be;
  logic        cap_we;
  int          sc;

  // Presents one op and holds it while stall is high; ack on REQ cycle ack_at
  // (0 = never). Returns in the retire cycle (or the cycle of a rejected op).
  task automatic run_op(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] mrd, output int stall_cnt);
    int rq;
    rq = 0;
    stall_cnt = 0;
    op_valid = 1'b1; op_write = w; op_size = sz; op_unsigned = uns;
    op_addr = a; op_wdata = wd; mem_rdata = mrd;
    cap_addr = '0; cap_wd = '0; cap_be = '0; cap_we = 1'b0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (!stall) break;
      stall_cnt++;
      if (mem_req) begin
        rq++;
        if (rq == 1) begin
          cap_addr = mem_addr; cap_wd = mem_wdata; cap_be = mem_be; cap_we = mem_we;
        end
      end
      mem_ack = (ack_at != 0 && rq == ack_at);
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    if (stall) chk("stall_bound", 32'(stall), 32'd0);
  endtask

  task automatic retire();
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_write = 1'b0; op_size = 2'b00; op_unsigned = 1'b0;
    op_addr = '0; op_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;

    // sw 0x104, ack on 3rd REQ cycle
    run_op(1'b1, 2'b00, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 3, 32'h0, sc);
    chk("sw_stall_cycles", 32'(sc), 32'd4);
    chk("sw_addr", cap_addr, 32'h0000_0104);
    chk("sw_be", 32'(cap_be), 32'hF);
    chk("sw_we", 32'(cap_we), 32'd1);
    chk("sw_wdata", cap_wd, 32'hDEAD_BEEF);
    chk("sw_rvalid", 32'(rdata_valid), 32'd0);
    retire();

    run_op(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 1, 32'h8001_1234, sc);
    chk("lh_stall_cycles", 32'(sc), 32'd2);
    chk("lh_rvalid", 32'(rdata_valid), 32'd1);
    chk("lh_rdata", rdata, 32'hFFFF_8001);
    retire();

    run_op(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 1, 32'h8001_1234, sc);
    chk("lhu_rdata", rdata, 32'h0000_8001);
    retire();

    run_op(1'b0, 2'b11, 1'b0, 32'h0000_0103, 32'h0, 2, 32'h8001_1234, sc);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    retire();

    run_op(1'b0, 2'b11, 1'b1, 32'h0000_0100, 32'h0, 1, 32'h8001_1234, sc);
    chk("lbu_rdata", rdata, 32'h0000_0034);
    retire();

    run_op(1'b1, 2'b11, 1'b0, 32'h0000_0021, 32'h0000_00AB, 1, 32'h0, sc);
    chk("sb_be", 32'(cap_be), 32'h2);
    chk("sb_wdata", cap_wd, 32'hABAB_ABAB);
    chk("sb_addr", cap_addr, 32'h0000_0020);
    retire();

    run_op(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_CAFE, 2, 32'h0, sc);
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wd, 32'hCAFE_CAFE);
    chk("rdata_hold", rdata, 32'h0000_0034);
    retire();

    // Misaligned word and reserved size
    run_op(1'b0, 2'b00, 1'b0, 32'h0000_0106, 32'h0, 1, 32'h0, sc);
    chk("lw_mis_stall", 32'(sc), 32'd0);
    retire();
    chk("lw_mis_addr_err", 32'(addr_err), 32'd1);
    chk("lw_mis_no_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    chk("lw_mis_pulse_end", 32'(addr_err), 32'd0);

    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h0, sc);
    chk("rsv_stall", 32'(sc), 32'd0);
    retire();
    chk("rsv_addr_err", 32'(addr_err), 32'd1);

    // Timeout, then ack on the final REQ cycle
    run_op(1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0, 0, 32'h5555_AAAA, sc);
    chk("to_stall_cycles", 32'(sc), 32'd5);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_rvalid", 32'(rdata_valid), 32'd0);
    retire();
    chk("to_pulse_end", 32'(timeout_err), 32'd0);

    run_op(1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0, 4, 32'h1122_3344, sc);
    chk("ack4_stall_cycles", 32'(sc), 32'd5);
    chk("ack4_to_err", 32'(timeout_err), 32'd0);
    chk("ack4_rvalid", 32'(rdata_valid), 32'd1);
    chk("ack4_rdata", rdata, 32'h1122_3344);
    retire();

    // Reset during REQ, then a late ack
    op_valid = 1'b1; op_write = 1'b0; op_size = 2'b00; op_addr = 32'h0000_0300;
    mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    chk("rstreq_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstreq_req_drop", 32'(mem_req), 32'd0);
    chk("rstreq_stall", 32'(stall), 32'd0);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_rvalid", 32'(rdata_valid), 32'd0);
    @(posedge clk); #1;
    chk("late_ack_rdata", rdata, 32'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Memory-stage load/store initiator; the requesting side of the data-memory interface.
- Takes a decoded load/store from the M stage and checks alignment.
- Drives a word-addressed memory port with byte enables and a req/ack handshake.
- Formats returned data (lane extract, sign/zero extend) and stalls the pipeline until the access completes.

Parameters:
- TIMEOUT, 255: maximum cycles in REQ without mem_ack before the access aborts; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- op_valid  in  1  M-stage instruction is a load or store
- op_write  in  1  1 = store, 0 = load
- op_size  in  2  00 word, 01 half, 11 byte, 10 reserved
- op_unsigned  in  1  zero-extend load (lbu/lhu); ignored for word
- op_addr  in  32  byte address
- op_wdata  in  32  store data, right-aligned
- stall  out  1  freeze the pipeline at or before M
- rdata  out  32  formatted load data
- rdata_valid  out  1  rdata valid; one-cycle pulse
- addr_err  out  1  misaligned or reserved-size access; one-cycle pulse
- timeout_err  out  1  access aborted on timeout; one-cycle pulse
- mem_req  out  1  request to memory
- mem_we  out  1  write request
- mem_addr  out  32  {op_addr[31:2], 2'b00}
- mem_be  out  4  byte-lane enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory accepted or completed the request
- mem_rdata  in  32  read word; valid only with mem_ack

Behaviour:
- Reset: on posedge with rst=1, state goes to IDLE. All registered outputs go to 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata, rdata_valid, addr_err, timeout_err. The timeout counter clears. rst mid-access drops mem_req on that same edge, and any later ack is ignored.
- States: IDLE, REQ, DONE.
- IDLE with op_valid=1:
  - Misalignment is: op_size=00 with addr[1:0]!=0; op_size=01 with addr[0]!=0; or op_size=10.
  - Misaligned: addr_err=1 on the next cycle only; stay IDLE; no request issued.
  - Aligned: register mem_addr, mem_we=op_write, mem_be, mem_wdata, size, unsigned and addr[1:0]; set mem_req=1; go to REQ; clear the counter.
- stall (combinational) = op_valid & ~misaligned & (state != DONE).
  - The pipeline holds op_* stable while stall=1.
  - The instruction retires at the end of the DONE cycle.
- REQ:
  - mem_req and all mem_* outputs stay stable until mem_ack.
  - On mem_ack: mem_req=0; for a load, rdata is formatted from mem_rdata; go to DONE.
  - Otherwise the counter increments. When counter==TIMEOUT-1 without ack: mem_req=0, timeout_err pulses, go to DONE.
  - mem_ack in the same cycle as expiry: the ack wins and there is no timeout_err.
- DONE: rdata_valid=1 for a load that completed with ack (0 for stores and timeouts); stall=0; go to IDLE next cycle.
- mem_ack in IDLE or DONE is ignored.
- Minimum latency with ack in the first REQ cycle: stall is high 2 cycles and the op retires in the 3rd.
- Byte enables:
  - word: 1111
  - half: addr[1] ? 1100 : 0011
  - byte: 0001 << addr[1:0]
- Store data:
  - word: op_wdata
  - half: {2{op_wdata[15:0]}}
  - byte: {4{op_wdata[7:0]}}
- Load format (little-endian lanes):
  - half: lane mem_rdata[31:16] if addr[1], else [15:0].
  - byte: lane mem_rdata[8*addr[1:0]+7 : 8*addr[1:0]].
  - Sign-extend from the lane MSB unless op_unsigned; word is passed through.
- rdata holds its value until the next load completes.

Test Plan:
- Aligned word store, addr 0x0000_0104, wdata 0xDEADBEEF, ack after 3 REQ cycles -> mem_addr 0x104, mem_be 1111, mem_we 1, stall high 4 cycles, no rdata_valid.
- lh at 0x102 with mem_rdata 0x8001_1234 -> rdata 0xFFFF_8001; lhu -> 0x0000_8001; lb at 0x103 -> 0xFFFF_FF80; lbu at 0x100 -> 0x0000_0034.
- sb at 0x21 with wdata 0x0000_00AB -> mem_be 0010, mem_wdata 0xABAB_ABAB; sh at 0x22 -> mem_be 1100.
- lw at 0x106 or op_size 10 -> addr_err one-cycle pulse, mem_req never asserted, stall 0.
- TIMEOUT=4, no ack -> mem_req high 4 cycles, then timeout_err pulse, rdata_valid 0, return to IDLE; repeat with ack on the 4th REQ cycle -> success, no timeout_err.
- rst asserted during REQ -> mem_req 0 after that edge, state IDLE; a late mem_ack produces no rdata_valid.
